mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_seq_ctrl_booth_step.sv | 29 ++
 rtl/mult_seq_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, step count and FSM state type for the Booth multiplier
package mult_pkg;
  localparam int MULT_W     = 32;
  localparam int MULT_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_seq_ctrl_booth_step.sv
// rtl/mult_seq_ctrl_booth_step.sv - one radix-2 Booth add/sub plus arithmetic right shift
module booth_step
  import mult_pkg::*;
(
  input  logic [2*MULT_W:0]  i_reg,
  input  logic [MULT_W-1:0]  i_mcand,
  output logic [2*MULT_W:0]  o_reg
);

  logic [MULT_W:0] w_acc;
  logic [MULT_W:0] w_mcand;
  logic [MULT_W:0] w_sum;

  // One guard bit keeps acc -/+ most-negative multiplicand from flipping the shifted-in sign.
  assign w_acc   = {i_reg[2*MULT_W], i_reg[2*MULT_W:MULT_W+1]};
  assign w_mcand = {i_mcand[MULT_W-1], i_mcand};

  always_comb begin
    w_sum = w_acc;
    case (i_reg[1:0])
      2'b01:   w_sum = w_acc + w_mcand;
      2'b10:   w_sum = w_acc - w_mcand;
      default: w_sum = w_acc;
    endcase
  end

  assign o_reg = {w_sum, i_reg[MULT_W:1]};

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequential 32x32 signed Booth multiplier; MULT_OVF_EN enables the over flag
module mult_seq_ctrl
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MULT_W-1:0] src_a,
  input  logic [MULT_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic [MULT_W-1:0] hi,
  output logic [MULT_W-1:0] lo,
  output logic              over
);

  localparam logic [4:0] LAST_STEP = 5'(MULT_STEPS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [MULT_W-1:0]    r_mcand;
  logic [2*MULT_W:0]    r_reg;
  logic [4:0]           r_cnt;
  logic [MULT_W-1:0]    r_hi;
  logic [MULT_W-1:0]    r_lo;
  logic [2*MULT_W:0]    w_step;
  logic                 w_last;

  booth_step u_booth_step (
    .i_reg   (r_reg),
    .i_mcand (r_mcand),
    .o_reg   (w_step)
  );

  assign w_last = (r_cnt == LAST_STEP);

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_reg   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (start) begin
          r_mcand <= src_a;
          r_reg   <= {{MULT_W{1'b0}}, src_b, 1'b0};
          r_cnt   <= '0;
        end
        RUN: begin
          r_reg <= w_step;
          // Counter parks at its last value rather than wrapping.
          if (w_last) begin
            r_hi <= w_step[2*MULT_W:MULT_W+1];
            r_lo <= w_step[MULT_W:1];
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

`ifdef MULT_OVF_EN
  logic r_over;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_over <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_over <= (w_step[2*MULT_W:MULT_W+1] != {MULT_W{w_step[MULT_W]}});
    end
  end

  assign over = r_over;
`else
  assign over = 1'b0;
`endif

endmodule
